writeback_stage: RTL
====================

Name: writeback_stage

Overview:
- Pipeline W register plus architectural register file and write-back logic for the Y86-64 pipelined core.
- Latches the memory-stage outputs (m_stat, m_icode, m_valE, m_valM, m_dstE, m_dstM) on each clock edge.
- Commits register writes and provides the two combinational read ports used by decode.
- Publishes the W-stage fields for decode forwarding and the processor status/halt indication.

Parameters:
- NREGS, 15, number of architectural registers; indices 0..14; index 15 (RNONE) means "no register".
- RSP_INIT, 64'd0, reset value of register 4 (%rsp); all other registers reset to 0.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- W_stall  in  1  hold the W register (from pipeline control).
- W_bubble  in  1  load a bubble into the W register.
- m_stat  in  3  status from the memory stage.
- m_icode  in  4  icode from the memory stage.
- m_valE  in  64  ALU result from the memory stage.
- m_valM  in  64  memory read data from the memory stage.
- m_dstE  in  4  E destination register.
- m_dstM  in  4  M destination register.
- d_srcA  in  4  decode read index A.
- d_srcB  in  4  decode read index B.
- d_rvalA  out  64  register read data A.
- d_rvalB  out  64  register read data B.
- W_stat  out  3  registered stat.
- W_icode  out  4  registered icode.
- W_valE  out  64  registered valE (forwarding source).
- W_valM  out  64  registered valM (forwarding source).
- W_dstE  out  4  registered dstE.
- W_dstM  out  4  registered dstM.
- Stat  out  3  processor status; equals W_stat, except SBUB maps to SAOK.
- halted  out  1  sticky halt flag.
- retired  out  CNT_W  retired-instruction count.

Behaviour:
- Clocking and reset:
  - Single clock.
  - Reset is synchronous and active-high, sampled on posedge clk, and has priority over everything else.
  - On reset: W_stat=SAOK, W_icode=INOP, W_dstE=W_dstM=RNONE, W_valE=W_valM=0, registers 0..14 = 0 except reg[RESP]=RSP_INIT, halted=0, retired=0.
  - Reset asserted mid-operation discards any in-flight W contents and any pending write on that edge.
- W register update, per edge, in priority order:
  - reset.
  - halted=1 or W_stall=1: hold all fields.
  - W_bubble=1: load bubble values (same as the reset values of the W fields).
  - otherwise: load the m_* inputs.
- Register write, on the edge, using the W contents present before the edge (one-cycle write latency after capture):
  - Enabled only when halted=0 and W_stat==SAOK.
  - If W_dstE!=RNONE: reg[W_dstE] <= W_valE.
  - If W_dstM!=RNONE: reg[W_dstM] <= W_valM.
  - If W_dstE==W_dstM!=RNONE (popq %rsp case): the valM write wins.
  - A W_stall on the same edge does not suppress the write. Pipeline control guarantees that a stalled W is either bubble or abnormal status, so no double write occurs.
- Halt:
  - halted <= 1 on any edge where reset=0 and W_stat is SHLT, SADR or SINS.
  - Once set, halted stays set until reset.
  - The faulting instruction's writes are suppressed.
  - The W register is frozen, so Stat holds the fault code.
- Retired counter:
  - Increments by 1 on edges where a write-enable condition holds and W_icode!=INOP, or W_icode==INOP with W_stat==SAOK (real nop).
  - Bubbles carry icode INOP and are not counted. Bubbles are distinguished by a registered valid bit set on loads from m_* and cleared on bubble/reset.
  - Wraps modulo 2^CNT_W.
- Read ports:
  - Purely combinational: d_rvalA = (d_srcA==RNONE) ? 0 : reg[d_srcA]; same for B.
  - No internal write-to-read bypass: a read in the same cycle as a write returns the old value. Decode forwards from W_* itself.
- Status encoding: SAOK=1, SADR=2, SINS=3, SHLT=4. Any other W_stat value is treated as abnormal (halts).

Decomposition:
- Shared package/header holds the icode constants (IHALT..IPOPQ), RNONE, RESP, and the stat codes SAOK/SADR/SINS/SHLT. These are shared with fetch, decode, execute and memory.
- One natural sub-module, regfile_2r2w: 15x64 storage, two combinational read ports, two write ports with port-M priority, and reset init.
- The W register, halt flag and counter live in writeback_stage.

Test Plan:
- Reset, then read all 15 indices -> 0 everywhere except reg4=RSP_INIT; Stat=SAOK; halted=0; retired=0.
- m_icode=IIRMOVQ, m_dstE=3, m_valE=0x1234, m_dstM=RNONE, m_stat=SAOK -> edge 1 sets W_valE=0x1234; after edge 2, d_srcA=3 gives 0x1234; retired=1.
- popq %rsp: m_dstE=4, m_valE=0x100, m_dstM=4, m_valM=0xABC -> reg4=0xABC after the commit edge.
- W_stall=1 with new m_* values -> W_* unchanged. W_bubble=1 -> W_icode=INOP, W_dstE=W_dstM=RNONE, no write, retired unchanged.
- m_stat=SADR, m_dstE=2, m_valE=7 -> reg2 not written; halted=1 one edge after the W capture; Stat=SADR thereafter; subsequent valid m_* inputs are ignored; reset clears everything.
- Same-cycle read/write of reg5 -> d_rvalA shows the old value in that cycle and the new value in the next cycle.

Source files
------------

// File: rtl/writeback_stage_pkg.sv
// Shared Y86-64 encodings (icodes, register ids, status codes) and the W-stage record.
// The fetch, decode, execute and memory stages import the same constants.
package writeback_stage_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RESP  = 4'h4;

  localparam logic [2:0] SBUB = 3'd0;
  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SADR = 3'd2;
  localparam logic [2:0] SINS = 3'd3;
  localparam logic [2:0] SHLT = 3'd4;

  // valid separates real instructions (including real nops) from bubbles.
  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [63:0] val_e;
    logic [63:0] val_m;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic        valid;
  } w_reg_t;

  function automatic w_reg_t bubble_w();
    w_reg_t b;
    b.stat  = SAOK;
    b.icode = INOP;
    b.val_e = 64'd0;
    b.val_m = 64'd0;
    b.dst_e = RNONE;
    b.dst_m = RNONE;
    b.valid = 1'b0;
    return b;
  endfunction

  function automatic logic is_abnormal(input logic [2:0] s);
    return s != SAOK;
  endfunction

endpackage

// File: rtl/writeback_stage_regfile_2r2w.sv
// Architectural register file: two combinational read ports, two write ports
// where port M overrides port E on the same index, synchronous reset init.
module regfile_2r2w
  import writeback_stage_pkg::*;
#(
  parameter int          NREGS    = 15,
  parameter logic [63:0] RSP_INIT = 64'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  src_a,
  input  logic [3:0]  src_b,
  output logic [63:0] rval_a,
  output logic [63:0] rval_b,
  input  logic        we_e,
  input  logic [3:0]  dst_e,
  input  logic [63:0] val_e,
  input  logic        we_m,
  input  logic [3:0]  dst_m,
  input  logic [63:0] val_m
);

  logic [63:0] regs [NREGS];

  // No write-to-read bypass: decode forwards from the W fields itself.
  assign rval_a = (src_a == RNONE || int'(src_a) >= NREGS) ? 64'd0 : regs[src_a];
  assign rval_b = (src_b == RNONE || int'(src_b) >= NREGS) ? 64'd0 : regs[src_b];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= (i == int'(RESP)) ? RSP_INIT : 64'd0;
      end
    end else begin
      if (we_e && int'(dst_e) < NREGS) regs[dst_e] <= val_e;
      // Issued last so popq %rsp keeps the popped value.
      if (we_m && int'(dst_m) < NREGS) regs[dst_m] <= val_m;
    end
  end

endmodule

// File: rtl/writeback_stage.sv
// Y86-64 write-back stage: W pipeline register, register-file commit,
// sticky halt on abnormal status and retired-instruction counter.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int          NREGS    = 15,
  parameter logic [63:0] RSP_INIT = 64'd0,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             W_stall,
  input  logic             W_bubble,
  input  logic [2:0]       m_stat,
  input  logic [3:0]       m_icode,
  input  logic [63:0]      m_valE,
  input  logic [63:0]      m_valM,
  input  logic [3:0]       m_dstE,
  input  logic [3:0]       m_dstM,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  output logic [63:0]      d_rvalA,
  output logic [63:0]      d_rvalB,
  output logic [2:0]       W_stat,
  output logic [3:0]       W_icode,
  output logic [63:0]      W_valE,
  output logic [63:0]      W_valM,
  output logic [3:0]       W_dstE,
  output logic [3:0]       W_dstM,
  output logic [2:0]       Stat,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  w_reg_t w_q;
  w_reg_t m_in;
  logic   w_abnormal;
  logic   commit;
  logic   hold;

  assign m_in = '{stat: m_stat, icode: m_icode, val_e: m_valE, val_m: m_valM,
                  dst_e: m_dstE, dst_m: m_dstM, valid: 1'b1};

  assign w_abnormal = is_abnormal(w_q.stat);
  assign commit     = !halted && (w_q.stat == SAOK);
  // A faulting instruction freezes W on the edge it raises halt, so Stat keeps the fault code.
  assign hold       = halted || W_stall || w_abnormal;

  always_ff @(posedge clk) begin
    if (reset) begin
      w_q <= bubble_w();
    end else if (!hold) begin
      w_q <= W_bubble ? bubble_w() : m_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      halted <= 1'b0;
    end else if (w_abnormal) begin
      halted <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      retired <= '0;
    end else if (commit && w_q.valid) begin
      retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  regfile_2r2w #(
    .NREGS    (NREGS),
    .RSP_INIT (RSP_INIT)
  ) u_regfile (
    .clk    (clk),
    .reset  (reset),
    .src_a  (d_srcA),
    .src_b  (d_srcB),
    .rval_a (d_rvalA),
    .rval_b (d_rvalB),
    .we_e   (commit && (w_q.dst_e != RNONE)),
    .dst_e  (w_q.dst_e),
    .val_e  (w_q.val_e),
    .we_m   (commit && (w_q.dst_m != RNONE)),
    .dst_m  (w_q.dst_m),
    .val_m  (w_q.val_m)
  );

  assign W_stat  = w_q.stat;
  assign W_icode = w_q.icode;
  assign W_valE  = w_q.val_e;
  assign W_valM  = w_q.val_m;
  assign W_dstE  = w_q.dst_e;
  assign W_dstM  = w_q.dst_m;
  assign Stat    = (w_q.stat == SBUB) ? SAOK : w_q.stat;

endmodule
